// File: rtl/l1_mem_arbiter.sv
// Two-port L1 refill arbiter: I-cache and D-cache share one line-wide memory port.
// Round-robin on ties, one request in flight, one-cycle DONE bubble after each reply.
module l1_mem_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int LINE_WIDTH = 128
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic [ADDR_WIDTH-1:0] ic_m_addr_i,
  input  logic                  ic_m_strobe_i,
  output logic [LINE_WIDTH-1:0] ic_m_dout_o,
  output logic                  ic_m_ready_o,
  input  logic [ADDR_WIDTH-1:0] dc_m_addr_i,
  input  logic                  dc_m_rw_i,
  input  logic [LINE_WIDTH-1:0] dc_m_din_i,
  input  logic                  dc_m_strobe_i,
  output logic [LINE_WIDTH-1:0] dc_m_dout_o,
  output logic                  dc_m_ready_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic                  mem_rw_o,
  output logic [LINE_WIDTH-1:0] mem_din_o,
  output logic                  mem_strobe_o,
  input  logic [LINE_WIDTH-1:0] mem_dout_i,
  input  logic                  mem_ready_i,
  output logic [1:0]            grant_o
);

  typedef enum logic [1:0] {
    IDLE,
    IC_BUSY,
    DC_BUSY,
    DONE
  } state_t;

  state_t                state, state_nxt;
  logic                  last_dc, last_dc_nxt;
  logic [ADDR_WIDTH-1:0] addr_q, addr_nxt;
  logic                  rw_q, rw_nxt;
  logic [LINE_WIDTH-1:0] din_q, din_nxt;
  logic                  pick_ic;

  // I-cache wins a tie only when the D-cache was served last
  assign pick_ic = ic_m_strobe_i & (~dc_m_strobe_i | last_dc);

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state   <= IDLE;
      last_dc <= 1'b1;
      addr_q  <= '0;
      rw_q    <= 1'b0;
      din_q   <= '0;
    end else begin
      state   <= state_nxt;
      last_dc <= last_dc_nxt;
      addr_q  <= addr_nxt;
      rw_q    <= rw_nxt;
      din_q   <= din_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    last_dc_nxt = last_dc;
    addr_nxt    = addr_q;
    rw_nxt      = rw_q;
    din_nxt     = din_q;
    unique case (state)
      IDLE: begin
        if (pick_ic) begin
          state_nxt = IC_BUSY;
          addr_nxt  = ic_m_addr_i;
          rw_nxt    = 1'b0;
          din_nxt   = '0;
        end else if (dc_m_strobe_i) begin
          state_nxt = DC_BUSY;
          addr_nxt  = dc_m_addr_i;
          rw_nxt    = dc_m_rw_i;
          din_nxt   = dc_m_din_i;
        end
      end
      IC_BUSY: begin
        if (mem_ready_i) begin
          state_nxt   = DONE;
          last_dc_nxt = 1'b0;
        end
      end
      DC_BUSY: begin
        if (mem_ready_i) begin
          state_nxt   = DONE;
          last_dc_nxt = 1'b1;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign mem_strobe_o = (state == IC_BUSY) | (state == DC_BUSY);
  assign mem_addr_o   = addr_q;
  assign mem_rw_o     = rw_q;
  assign mem_din_o    = din_q;
  assign grant_o      = {state == DC_BUSY, state == IC_BUSY};

  // a reply arriving while reset is asserted is never forwarded
  assign ic_m_ready_o = rst_ni & (state == IC_BUSY) & mem_ready_i;
  assign dc_m_ready_o = rst_ni & (state == DC_BUSY) & mem_ready_i;
  assign ic_m_dout_o  = ic_m_ready_o ? mem_dout_i : '0;
  assign dc_m_dout_o  = dc_m_ready_o ? mem_dout_i : '0;

endmodule

// File: tb/tb_l1_mem_arbiter.sv
// Bench for l1_mem_arbiter: directed scenarios then random traffic,
// every cycle compared against a transaction-level reference model.
module tb_l1_mem_arbiter;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [31:0]  ic_addr = '0;
  logic         ic_strobe = 1'b0;
  logic [127:0] ic_dout;
  logic         ic_ready;
  logic [31:0]  dc_addr = '0;
  logic         dc_rw = 1'b0;
  logic [127:0] dc_din = '0;
  logic         dc_strobe = 1'b0;
  logic [127:0] dc_dout;
  logic         dc_ready;
  logic [31:0]  mem_addr;
  logic         mem_rw;
  logic [127:0] mem_din;
  logic         mem_strobe;
  logic [127:0] mem_dout = '0;
  logic         mem_ready = 1'b0;
  logic [1:0]   grant;

  always #5 clk = ~clk;

  l1_mem_arbiter dut (
    .clk_i(clk),
    .rst_ni(rst_n),
    .ic_m_addr_i(ic_addr),
    .ic_m_strobe_i(ic_strobe),
    .ic_m_dout_o(ic_dout),
    .ic_m_ready_o(ic_ready),
    .dc_m_addr_i(dc_addr),
    .dc_m_rw_i(dc_rw),
    .dc_m_din_i(dc_din),
    .dc_m_strobe_i(dc_strobe),
    .dc_m_dout_o(dc_dout),
    .dc_m_ready_o(dc_ready),
    .mem_addr_o(mem_addr),
    .mem_rw_o(mem_rw),
    .mem_din_o(mem_din),
    .mem_strobe_o(mem_strobe),
    .mem_dout_i(mem_dout),
    .mem_ready_i(mem_ready),
    .grant_o(grant)
  );

  int n_pass = 0;
  int n_total = 0;

  // model: who owns the port (0 none, 1 I, 2 D), bubble pending, last served
  int           m_owner = 0;
  bit           m_bubble = 0;
  int           m_last = 2;
  logic [31:0]  m_addr = '0;
  logic         m_rw = 1'b0;
  logic [127:0] m_din = '0;

  bit           ic_seen, dc_seen;
  int           strobe_cnt, ic_pulses, dc_pulses;
  logic [1:0]   prev_grant = 2'b00;
  logic [1:0]   gseq[$];

  task automatic chk(string tag, logic [127:0] obs, logic [127:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic step(string ph);
    logic [1:0]   eg;
    logic         eic, edc;
    logic [127:0] eicd, edcd;
    #4;
    eg   = (m_owner == 1) ? 2'b01 : (m_owner == 2) ? 2'b10 : 2'b00;
    eic  = rst_n && m_owner == 1 && mem_ready;
    edc  = rst_n && m_owner == 2 && mem_ready;
    eicd = eic ? mem_dout : '0;
    edcd = edc ? mem_dout : '0;
    chk({ph, ".grant"}, grant, eg);
    chk({ph, ".strobe"}, mem_strobe, m_owner != 0);
    chk({ph, ".addr"}, mem_addr, m_addr);
    chk({ph, ".rw"}, mem_rw, m_rw);
    chk({ph, ".din"}, mem_din, m_din);
    chk({ph, ".ic_ready"}, ic_ready, eic);
    chk({ph, ".ic_dout"}, ic_dout, eicd);
    chk({ph, ".dc_ready"}, dc_ready, edc);
    chk({ph, ".dc_dout"}, dc_dout, edcd);
    if (mem_strobe) strobe_cnt++;
    if (ic_ready) ic_pulses++;
    if (dc_ready) dc_pulses++;
    if (grant != 2'b00 && prev_grant == 2'b00) gseq.push_back(grant);
    prev_grant = grant;
    ic_seen = eic;
    dc_seen = edc;
    if (!rst_n) begin
      m_owner = 0; m_bubble = 0; m_last = 2;
      m_addr = '0; m_rw = 1'b0; m_din = '0;
    end else if (m_owner != 0) begin
      if (mem_ready) begin
        m_last = m_owner; m_owner = 0; m_bubble = 1;
      end
    end else if (m_bubble) begin
      m_bubble = 0;
    end else if (ic_strobe && (!dc_strobe || m_last == 2)) begin
      m_owner = 1; m_addr = ic_addr; m_rw = 1'b0; m_din = '0;
    end else if (dc_strobe) begin
      m_owner = 2; m_addr = dc_addr; m_rw = dc_rw; m_din = dc_din;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic clr_cnt();
    strobe_cnt = 0; ic_pulses = 0; dc_pulses = 0;
    gseq.delete();
  endtask

  bit ic_pend, dc_pend;

  initial begin
    clr_cnt();
    @(posedge clk);
    #1;
    step("rst0");
    step("rst1");
    rst_n = 1'b1;
    step("idle");

    // I-cache alone, memory answers on the third busy cycle
    clr_cnt();
    ic_addr = 32'h0000_1000; ic_strobe = 1'b1;
    step("ic1");
    step("ic1");
    step("ic1");
    mem_ready = 1'b1; mem_dout = {16{8'hA5}};
    step("ic1");
    ic_strobe = 1'b0; mem_ready = 1'b0;
    step("ic1");
    chk("ic1.strobe_cycles", strobe_cnt, 3);
    chk("ic1.ic_pulses", ic_pulses, 1);
    chk("ic1.dc_pulses", dc_pulses, 0);

    // simultaneous first requests after reset
    rst_n = 1'b0;
    step("rst2");
    rst_n = 1'b1;
    clr_cnt();
    ic_addr = 32'h100; ic_strobe = 1'b1;
    dc_addr = 32'h200; dc_rw = 1'b1; dc_din = {16{8'h11}};
    dc_strobe = 1'b1; mem_ready = 1'b1; mem_dout = {4{32'hCAFE_0001}};
    for (int i = 0; i < 8; i++) begin
      step("tie");
      if (ic_seen) ic_strobe = 1'b0;
      if (dc_seen) dc_strobe = 1'b0;
    end
    chk("tie.n", gseq.size(), 2);
    if (gseq.size() == 2) begin
      chk("tie.first", gseq[0], 2'b01);
      chk("tie.second", gseq[1], 2'b10);
    end

    // both held: strict alternation
    clr_cnt();
    ic_strobe = 1'b1; dc_strobe = 1'b1; dc_rw = 1'b0;
    for (int i = 0; i < 12; i++) step("alt");
    chk("alt.n", gseq.size(), 4);
    for (int i = 0; i < gseq.size() && i < 4; i++)
      chk("alt.seq", gseq[i], (i % 2 == 0) ? 2'b01 : 2'b10);
    ic_strobe = 1'b0; dc_strobe = 1'b0; mem_ready = 1'b0;
    step("alt_end");
    step("alt_end");

    // D-cache drops strobe early; transaction still completes
    clr_cnt();
    dc_addr = 32'h300; dc_rw = 1'b0; dc_strobe = 1'b1;
    step("drop");
    dc_strobe = 1'b0;
    for (int i = 0; i < 4; i++) step("drop");
    mem_ready = 1'b1; mem_dout = {4{32'h0BAD_F00D}};
    step("drop");
    mem_ready = 1'b0;
    step("drop");
    chk("drop.dc_pulses", dc_pulses, 1);
    chk("drop.strobe_cycles", strobe_cnt, 5);

    // spurious memory reply while idle
    clr_cnt();
    mem_ready = 1'b1;
    for (int i = 0; i < 3; i++) step("spur");
    chk("spur.pulses", ic_pulses + dc_pulses, 0);
    chk("spur.grants", gseq.size(), 0);
    mem_ready = 1'b0;

    // reset in the middle of an I-cache transaction
    dc_strobe = 1'b1; dc_addr = 32'h500;
    step("pre");
    mem_ready = 1'b1;
    step("pre");
    dc_strobe = 1'b0; mem_ready = 1'b0;
    step("pre");
    step("pre");
    clr_cnt();
    ic_addr = 32'h4000; ic_strobe = 1'b1;
    step("mid");
    step("mid");
    rst_n = 1'b0; ic_strobe = 1'b0;
    step("mid");
    rst_n = 1'b1; mem_ready = 1'b1;
    step("mid");
    chk("mid.strobe_after_rst", mem_strobe, 1'b0);
    step("mid");
    chk("mid.ic_pulses", ic_pulses, 0);
    mem_ready = 1'b0;
    clr_cnt();
    ic_strobe = 1'b1; dc_strobe = 1'b1;
    step("mid");
    step("mid");
    chk("mid.tie_first", gseq.size() > 0 ? gseq[0] : 2'b00, 2'b01);
    ic_strobe = 1'b0; dc_strobe = 1'b0;
    step("mid");
    step("mid");
    step("mid");

    // random traffic
    ic_pend = 0; dc_pend = 0;
    for (int c = 0; c < 3000; c++) begin
      if (!ic_pend && $urandom_range(2) == 0) begin
        ic_pend = 1; ic_strobe = 1'b1; ic_addr = $urandom;
      end
      if (!dc_pend && $urandom_range(2) == 0) begin
        dc_pend = 1; dc_strobe = 1'b1; dc_addr = $urandom;
        dc_rw = 1'($urandom_range(1));
        dc_din = {$urandom, $urandom, $urandom, $urandom};
      end
      if (m_owner == 1 && $urandom_range(29) == 0) ic_strobe = 1'b0;
      if (m_owner == 2 && $urandom_range(29) == 0) dc_strobe = 1'b0;
      mem_ready = ($urandom_range(2) == 0);
      mem_dout = {$urandom, $urandom, $urandom, $urandom};
      rst_n = ($urandom_range(199) != 0);
      step("rnd");
      if (ic_seen || !rst_n) begin ic_pend = 0; ic_strobe = 1'b0; end
      if (dc_seen || !rst_n) begin dc_pend = 0; dc_strobe = 1'b0; end
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/l1_mem_arbiter.md
L1_MEM_ARBITER -- requirements
Module: l1_mem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32, meaning memory byte-address width.
REQ-002 SHALL have parameter LINE_WIDTH, default 128, meaning cache-line data width (equal to ICACHE_LINE_SIZE).
REQ-003 SHALL have port clk_i  input  1  system clock; one clock, all state on rising edge.
REQ-004 SHALL have port rst_ni  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port ic_m_addr_i  input  ADDR_WIDTH  I-cache refill line address.
REQ-006 SHALL have port ic_m_strobe_i  input  1  I-cache refill request, level, held until ic_m_ready_o.
REQ-007 SHALL have port ic_m_dout_o  output  LINE_WIDTH  refill line returned to I-cache.
REQ-008 SHALL have port ic_m_ready_o  output  1  one-cycle completion pulse to I-cache.
REQ-009 SHALL have port dc_m_addr_i  input  ADDR_WIDTH  D-cache line address.
REQ-010 SHALL have port dc_m_rw_i  input  1  D-cache op: 0 = line read, 1 = line write-back.
REQ-011 SHALL have port dc_m_din_i  input  LINE_WIDTH  D-cache write-back data.
REQ-012 SHALL have port dc_m_strobe_i  input  1  D-cache request, level, held until dc_m_ready_o.
REQ-013 SHALL have port dc_m_dout_o  output  LINE_WIDTH  line returned to D-cache.
REQ-014 SHALL have port dc_m_ready_o  output  1  one-cycle completion pulse to D-cache.
REQ-015 SHALL have ports mem_addr_o, mem_rw_o, mem_din_o, mem_strobe_o  output  ADDR_WIDTH/1/LINE_WIDTH/1  shared memory request.
REQ-016 SHALL have ports mem_dout_i  input  LINE_WIDTH and mem_ready_i  input  1  shared memory response.
REQ-017 SHALL have port grant_o  output  2  current owner: 00 none, 01 I-cache, 10 D-cache.

Function
REQ-018 SHALL implement FSM states IDLE, IC_BUSY, DC_BUSY, DONE.
REQ-019 IDLE: only ic strobe -> IC_BUSY; only dc strobe -> DC_BUSY; both -> requester not served last (round-robin), else stay IDLE.
REQ-020 SHALL latch winner's addr, rw (0 for I-cache), din into request registers on the IDLE->BUSY edge.
REQ-021 mem_strobe_o SHALL be 1 exactly while state is IC_BUSY or DC_BUSY; mem_addr_o/mem_rw_o/mem_din_o SHALL drive latched registers, stable for the whole transaction.
REQ-022 Latency: strobe sampled high in IDLE at edge N -> mem_strobe_o high from cycle N+1.
REQ-023 BUSY with mem_ready_i=1: owner's ready_o SHALL be 1 in that same cycle (combinational), dout_o = mem_dout_i in that cycle; state -> DONE; last-served flag updated to owner.
REQ-024 Non-owner ready_o SHALL stay 0 in all cycles; dout_o outputs SHALL be 0 when not pulsing ready.
REQ-025 DONE SHALL last exactly one cycle, mem_strobe_o=0, no grant, then -> IDLE (bubble so requester drops stale strobe).
REQ-026 mem_ready_i in IDLE or DONE SHALL be ignored (no ready_o pulse, no state change).
REQ-027 Requester dropping strobe mid-transaction SHALL NOT abort; transaction completes, ready still pulsed.
REQ-028 New request arriving while BUSY SHALL wait; no preemption; back-to-back requests from both sides SHALL alternate.
REQ-029 grant_o SHALL reflect state: IC_BUSY 01, DC_BUSY 10, else 00.

Reset
REQ-030 On rst_ni=0 at a rising edge: state IDLE, request registers 0, last-served = D-cache (I-cache wins first tie).
REQ-031 During/after reset: mem_strobe_o 0, mem_addr_o 0, mem_rw_o 0, mem_din_o 0, ic/dc ready_o 0, dout_o 0, grant_o 00.
REQ-032 Reset mid-transaction SHALL abandon it: mem_strobe_o 0 from the first edge rst_ni sampled low; no ready pulse later.

Verification
REQ-033 I-cache only: ic addr 0x0000_1000, mem_ready after 3 cycles with dout 0xA5..A5 -> mem_strobe 1 for 3 cycles, addr 0x1000, rw 0; ic_m_ready_o one pulse with 0xA5..A5; dc_m_ready_o 0.
REQ-034 Simultaneous first requests (ic 0x100, dc write 0x200 din 0x11..11) after reset -> I-cache served first, then D-cache with rw 1, din 0x11..11; exactly one DONE bubble between.
REQ-035 Both strobes held continuously for 4 transactions -> grant sequence 01,10,01,10.
REQ-036 dc read 0x300, dc strobe dropped after 1 cycle, mem_ready after 5 -> transaction still completes, dc_m_ready_o pulses once, addr stable 0x300.
REQ-037 Spurious mem_ready_i=1 in IDLE -> no ready pulse, grant_o stays 00.
REQ-038 rst_ni low for 1 cycle during IC_BUSY -> mem_strobe_o 0 next cycle, late mem_ready_i produces no ic_m_ready_o, next tie goes to I-cache.
